// File: rtl/i2s_clk_sequencer.sv
// Master-mode I2S timing controller: generates BCLK/LRCLK from programmable
// dividers, single-cycle phase strobes for the serializer/deserializer, and
// sequences the upstream stereo-pair fetch with sticky underrun detection.
// Start is immediate; stop is deferred to the next frame boundary.
module i2s_clk_sequencer #(
  parameter int unsigned DIV_HALF  = 8,
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  input  logic clr_underrun,
  input  logic sample_valid,
  output logic sample_req,
  output logic bclk,
  output logic lrclk,
  output logic bclk_rise_stb,
  output logic bclk_fall_stb,
  output logic frame_stb,
  output logic load_stb,
  output logic underrun,
  output logic busy
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_HALF - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             pair_held;

  logic running_c;
  logic accept_c;
  logic div_wrap_c;
  logic word_wrap_c;
  logic boundary_c;
  logic stop_now_c;
  logic frame_c;
  logic held_now_c;
  logic underrun_set_c;

  // Event decode for the current cycle: divider wrap, word wrap, frame boundary, handshake
  always_comb begin
    running_c      = 1'b0;
    accept_c       = 1'b0;
    div_wrap_c     = 1'b0;
    word_wrap_c    = 1'b0;
    boundary_c     = 1'b0;
    stop_now_c     = 1'b0;
    frame_c        = 1'b0;
    held_now_c     = 1'b0;
    underrun_set_c = 1'b0;

    running_c   = (state != IDLE);
    accept_c    = sample_req && sample_valid;
    div_wrap_c  = running_c && (div_cnt == DIV_LAST);
    // word wrap only on a falling BCLK edge, so LRCLK moves with BCLK falls
    word_wrap_c = div_wrap_c && bclk && (bit_cnt == WORD_LAST);
    boundary_c  = word_wrap_c && lrclk;
    // a re-raised enable at the boundary keeps the controller running
    stop_now_c  = boundary_c && (state == STOPPING) && !enable;
    frame_c     = boundary_c && !stop_now_c;
    // a pair accepted in the last cycle before frame_stb still counts as on time
    held_now_c     = pair_held || accept_c;
    underrun_set_c = frame_c && !held_now_c;
  end

  // Sequencer: state, dividers, clock outputs, strobes and sample handshake
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      pair_held     <= 1'b0;
      sample_req    <= 1'b0;
      bclk          <= 1'b0;
      lrclk         <= 1'b0;
      bclk_rise_stb <= 1'b0;
      bclk_fall_stb <= 1'b0;
      frame_stb     <= 1'b0;
      load_stb      <= 1'b0;
      underrun      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      bclk_rise_stb <= 1'b0;
      bclk_fall_stb <= 1'b0;
      frame_stb     <= 1'b0;
      load_stb      <= 1'b0;

      // set has priority over clear
      if (underrun_set_c) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            // priming frame: no load, no underrun check, request the first pair
            state      <= RUN;
            busy       <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            frame_stb  <= 1'b1;
            sample_req <= 1'b1;
          end
        end

        default: begin
          if ((state == RUN) && !enable) begin
            state <= STOPPING;
          end else if ((state == STOPPING) && enable) begin
            state <= RUN;
          end

          if (accept_c) begin
            sample_req <= 1'b0;
            pair_held  <= 1'b1;
          end

          if (!div_wrap_c) begin
            div_cnt <= div_cnt + CNT_W'(1);
          end else begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (!bclk) begin
              bclk_rise_stb <= 1'b1;
            end else if (!word_wrap_c) begin
              bclk_fall_stb <= 1'b1;
              bit_cnt       <= bit_cnt + CNT_W'(1);
            end else if (!lrclk) begin
              // left -> right: fetch the pair for the next frame
              bclk_fall_stb <= 1'b1;
              bit_cnt       <= '0;
              lrclk         <= 1'b1;
              sample_req    <= 1'b1;
            end else if (stop_now_c) begin
              // frame complete while stopping: park with clocks low
              state      <= IDLE;
              busy       <= 1'b0;
              bit_cnt    <= '0;
              lrclk      <= 1'b0;
              sample_req <= 1'b0;
              pair_held  <= 1'b0;
            end else begin
              bclk_fall_stb <= 1'b1;
              bit_cnt       <= '0;
              lrclk         <= 1'b0;
              frame_stb     <= 1'b1;
              if (held_now_c) begin
                load_stb  <= 1'b1;
                pair_held <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
